truth_table_sweeper: RTL
========================

# truth_table_sweeper

Sequential characterizer for 3-input single-output combinational logic blocks. On `start` it drives all eight input combinations into the device under characterization and samples that device's output for each row. It then reports the resulting 8-bit truth-table identifier, so a block implementing the constant-zero function reports 0x00. It sits beside any 3-input logic module in the verification/characterization harness, driving that module's `in1`/`in2`/`in3` and observing its `out`.

## Interface
- `SETTLE_CYCLES`, default 2: extra hold cycles per row before sampling; legal range 0..15.
- `clk`  input  1  single clock; all state changes on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request a sweep; sampled only in IDLE.
- `dut_out`  input  1  output of the logic block under characterization.
- `drv_in1`  output  1  drives the block's `in1` (row bit 2, MSB).
- `drv_in2`  output  1  drives the block's `in2` (row bit 1).
- `drv_in3`  output  1  drives the block's `in3` (row bit 0).
- `busy`  output  1  high while a sweep is in progress.
- `done`  output  1  one-cycle pulse when the table is complete.
- `valid`  output  1  `table_out` holds a complete result.
- `table_out`  output  8  truth table; bit i = `dut_out` sampled with row i = {in1,in2,in3}.

## Operation
- FSM states: IDLE, APPLY.
- IDLE:
  - `drv_in*` = 0, `busy` = 0.
  - `start` = 1 → APPLY with row = 0, settle count = 0, `busy` = 1, `valid` = 0, shift register cleared.
- APPLY:
  - Drives row onto `drv_in1..3`. The settle counter counts 0..SETTLE_CYCLES.
  - On the edge where the count equals SETTLE_CYCLES, `dut_out` is captured into bit[row], the count resets, and the row increments.
  - After row 7 is captured: `table_out` is loaded, `valid` = 1, `done` = 1 for one cycle, `busy` = 0, and the FSM returns to IDLE.
- `start` while `busy` is ignored; no queuing.
- `start` during the `done` cycle (FSM already in IDLE) is accepted. `valid` then drops on the following edge.
- `valid` and `table_out` hold until the next accepted `start`.
- `dut_out` is treated as synchronous to `clk`; no synchronizer.
- Row counter is 3 bits and never wraps within a sweep. Termination is on row 7 capture, not on overflow.

## Timing
- Reset values: `drv_in1..3` = 0, `busy` = 0, `done` = 0, `valid` = 0, `table_out` = 0x00, FSM = IDLE. Under SWEEP_COMPARE_EN, also `match` = 0 and `mismatch_row` = 0.
- Reset asserted mid-sweep aborts immediately: all outputs go to reset values and no partial table is exposed.
- Let E0 be the edge that accepts `start`.
- Row k is driven from edge E0 + k·(SETTLE_CYCLES+1) and sampled at edge E0 + (k+1)·(SETTLE_CYCLES+1).
- `done`, `valid` and `table_out` update at edge E0 + 8·(SETTLE_CYCLES+1). That is 24 cycles for the default and 8 cycles for SETTLE_CYCLES = 0.
- All outputs are registered. `drv_in*` change only on edges.

## Configuration
- `SWEEP_COMPARE_EN` defined:
  - Adds input `expected[7:0]` and outputs `match` (1 bit) and `mismatch_row[2:0]`.
  - `expected` is sampled at the edge that accepts `start`.
  - `match` and `mismatch_row` are registered and update together with `valid`. `match` = (table == expected).
  - `mismatch_row` = lowest index i where the bits differ, and 0 when `match` is 1.
  - Both clear to 0 on `start` acceptance and on reset.
- `SWEEP_COMPARE_EN` undefined: these ports and their logic are absent. Everything else is identical.

## Test plan
- Constant-zero block, SETTLE_CYCLES = 2, `start` pulse:
  - `busy` is high for 24 cycles.
  - `done` pulses at E0+24.
  - `table_out` = 0x00 and `valid` = 1.
- 3-input AND block → `table_out` = 0x80. Pass-through of `in1` → 0xF0. Both checked with `drv_in*` stepping through rows 0..7 in order.
- XOR3 block, SETTLE_CYCLES = 0:
  - `table_out` = 0x96, `done` at E0+8.
  - Each row is held for exactly one cycle.
- Re-issue `start` while `busy` → no effect on the timeline. Then `start` in the `done` cycle → a new sweep begins, and `valid` drops on the next edge.
- Assert `rst_n` = 0 during row 4 → all outputs go to 0 asynchronously. After release the FSM is in IDLE and `valid` = 0.
- With SWEEP_COMPARE_EN, AND block:
  - `expected` = 0x80 → `match` = 1.
  - `expected` = 0x81 → `match` = 0 and `mismatch_row` = 0.
  - `expected` = 0x00 → `mismatch_row` = 7.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Drives all eight input rows into a 3-input logic block and assembles its 8-bit truth table.
// Optional SWEEP_COMPARE_EN adds an expected-table input with match / first-mismatch-row outputs.
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dut_out,
`ifdef SWEEP_COMPARE_EN
  input  logic [7:0] expected,
  output logic       match,
  output logic [2:0] mismatch_row,
`endif
  output logic       drv_in1,
  output logic       drv_in2,
  output logic       drv_in3,
  output logic       busy,
  output logic       done,
  output logic       valid,
  output logic [7:0] table_out
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] APPLY = 1'b1;
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);

  logic [0:0] state_q, state_d;
  logic [2:0] row_q,   row_d;
  logic [3:0] cnt_q,   cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] table_q, table_d;
  logic       valid_q, valid_d;
  logic       done_q,  done_d;

`ifdef SWEEP_COMPARE_EN
  logic [7:0] expected_q, expected_d;
  logic       match_q,    match_d;
  logic [2:0] mm_row_q,   mm_row_d;
  logic [7:0] diff;
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    table_d = table_q;
    valid_d = valid_q;
    done_d  = 1'b0;
`ifdef SWEEP_COMPARE_EN
    expected_d = expected_q;
    match_d    = match_q;
    mm_row_d   = mm_row_q;
    diff       = 8'h00;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = APPLY;
          row_d   = 3'd0;
          cnt_d   = 4'd0;
          valid_d = 1'b0;
          shift_d = 8'h00;
`ifdef SWEEP_COMPARE_EN
          expected_d = expected;
          match_d    = 1'b0;
          mm_row_d   = 3'd0;
`endif
        end
      end
      APPLY: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d          = 4'd0;
          shift_d[row_q] = dut_out;
          if (row_q == 3'd7) begin
            // Last row captured: publish the table and park the drivers at row 0.
            table_d = shift_d;
            valid_d = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
            row_d   = 3'd0;
`ifdef SWEEP_COMPARE_EN
            diff    = shift_d ^ expected_q;
            match_d = (diff == 8'h00);
            for (int i = 7; i >= 0; i--) begin
              if (diff[i]) mm_row_d = 3'(i);
            end
`endif
          end else begin
            row_d = row_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the table shift register is reset along with the control state so an
  // aborted sweep never leaves a partial table behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= 3'd0;
      cnt_q   <= 4'd0;
      shift_q <= 8'h00;
      table_q <= 8'h00;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef SWEEP_COMPARE_EN
      expected_q <= 8'h00;
      match_q    <= 1'b0;
      mm_row_q   <= 3'd0;
`endif
    end else begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      table_q <= table_d;
      valid_q <= valid_d;
      done_q  <= done_d;
`ifdef SWEEP_COMPARE_EN
      expected_q <= expected_d;
      match_q    <= match_d;
      mm_row_q   <= mm_row_d;
`endif
    end
  end

  assign drv_in1   = row_q[2];
  assign drv_in2   = row_q[1];
  assign drv_in3   = row_q[0];
  assign busy      = (state_q == APPLY);
  assign done      = done_q;
  assign valid     = valid_q;
  assign table_out = table_q;
`ifdef SWEEP_COMPARE_EN
  assign match        = match_q;
  assign mismatch_row = mm_row_q;
`endif

endmodule
